// File: rtl/reg_bank_8x.sv
// Eight-entry register bank with one synchronous write port and two combinational
// read ports (rs/rt style). Entry 0 can be hardwired to zero; reads can bypass the write.
module reg_bank_8x #(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       raddr_a,
    input  logic [2:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [3:0]       wr_count
);

    logic [WIDTH-1:0] regs [8];
    logic [7:0]       wr_en;
    logic             zero_drop;
    logic             accept;

    // A write to entry 0 is discarded entirely when it is hardwired to zero.
    assign zero_drop = (ZERO_REG != 0) && (waddr == 3'd0);
    assign accept    = we && !zero_drop;

    // Per-entry decoded enables: an unknown address bit only reaches entries it could select.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < 8; i++) begin
            if (!((ZERO_REG != 0) && (i == 0))) begin
                wr_en[i] = we && (waddr == 3'(i));
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs[g] <= '0;
            end else if (wr_en[g]) begin
                regs[g] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= 4'd0;
        end else if (accept && (wr_count != 4'd15)) begin
            wr_count <= wr_count + 4'd1;
        end
    end

    // Read select follows mux_8to1 order (000 -> entry 0 ... 111 -> entry 7).
    function automatic logic [WIDTH-1:0] read_port(input logic [2:0] addr);
        logic [WIDTH-1:0] value;
        value = regs[addr];
        if ((BYPASS != 0) && accept && (addr == waddr)) begin
            value = wdata;
        end
        return value;
    endfunction

    always_comb begin
        rdata_a = read_port(raddr_a);
        rdata_b = read_port(raddr_b);
    end

endmodule

// File: tb/tb_reg_bank_8x.sv
// Self-checking bench for reg_bank_8x: a write-first/zero-reg instance and a
// read-before-write/plain-entry-0 instance share stimulus, checked against array models.
module tb_reg_bank_8x;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         we;
    logic [2:0]   waddr;
    logic [W-1:0] wdata;
    logic [2:0]   raddr_a;
    logic [2:0]   raddr_b;
    logic [W-1:0] rd_a_z, rd_b_z, rd_a_n, rd_b_n;
    logic [3:0]   cnt_z, cnt_n;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: "z" = ZERO_REG=1/BYPASS=1, "n" = ZERO_REG=0/BYPASS=0.
    logic [W-1:0] mem_z [8];
    logic [W-1:0] mem_n [8];
    int           wc_z;
    int           wc_n;
    logic [W-1:0] exp_q [$];

    reg_bank_8x #(.WIDTH(W), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd_a_z), .rdata_b(rd_b_z), .wr_count(cnt_z)
    );

    reg_bank_8x #(.WIDTH(W), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd_a_n), .rdata_b(rd_b_n), .wr_count(cnt_n)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mem_z[i] = '0;
            mem_n[i] = '0;
        end
        wc_z = 0;
        wc_n = 0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [W-1:0] d);
        if (a != 3'd0) begin
            mem_z[a] = d;
            wc_z = (wc_z < 15) ? wc_z + 1 : 15;
        end
        mem_n[a] = d;
        wc_n = (wc_n < 15) ? wc_n + 1 : 15;
    endtask

    // Expected combinational read before the coming edge.
    function automatic logic [W-1:0] exp_z(input logic [2:0] a);
        if (we && rst_n && (a == waddr) && (waddr != 3'd0)) return wdata;
        return mem_z[a];
    endfunction

    function automatic logic [W-1:0] exp_n(input logic [2:0] a);
        return mem_n[a];
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input logic w, input logic [2:0] a, input logic [W-1:0] d);
        @(negedge clk);
        we    = w;
        waddr = a;
        wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        if (we && rst_n) model_write(waddr, wdata);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [W-1:0] d);
        drive(1'b1, a, d);
        tick();
        we = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        write_reg(3'd5, 32'hDEADBEEF);
        raddr_a = 3'd5;
        raddr_b = 3'd5;
        #1;
        n_cmp++;
        if (rd_a_z !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL pre_reset_read: got %h expected %h", rd_a_z, 32'hDEADBEEF);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (rd_a_z !== '0 || rd_b_n !== '0) begin
            n_err++;
            $display("FAIL async_reset_read: got %h/%h expected 0", rd_a_z, rd_b_n);
        end
        n_cmp++;
        if (cnt_z !== 4'd0 || cnt_n !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset_count: got %0d/%0d expected 0", cnt_z, cnt_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [W-1:0] e;
        for (int k = 1; k < 8; k++) write_reg(3'(k), 32'h11111111 * k);
        for (int a = 0; a < 8; a++) begin
            raddr_a = 3'(a);
            raddr_b = 3'(7 - a);
            #1;
            exp_q.push_back((a == 0) ? 32'h0 : 32'h11111111 * a);
            exp_q.push_back((a == 7) ? 32'h0 : 32'h11111111 * (7 - a));
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_a_z !== e || rd_a_n !== e) begin
                n_err++;
                $display("FAIL sweep_port_a[%0d]: got %h/%h expected %h", a, rd_a_z, rd_a_n, e);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_b_z !== e || rd_b_n !== e) begin
                n_err++;
                $display("FAIL sweep_port_b[%0d]: got %h/%h expected %h", 7 - a, rd_b_z, rd_b_n, e);
            end
        end
        n_cmp++;
        if (cnt_z !== 4'd7 || cnt_n !== 4'd7) begin
            n_err++;
            $display("FAIL sweep_count: got %0d/%0d expected 7", cnt_z, cnt_n);
        end
    endtask

    task automatic test_zero_reg();
        write_reg(3'd0, 32'hFFFFFFFF);
        raddr_a = 3'd0;
        raddr_b = 3'd0;
        #1;
        n_cmp++;
        if (rd_a_z !== '0 || rd_b_z !== '0) begin
            n_err++;
            $display("FAIL zero_reg_read: got %h/%h expected 0", rd_a_z, rd_b_z);
        end
        n_cmp++;
        if (cnt_z !== 4'd7) begin
            n_err++;
            $display("FAIL zero_reg_count: got %0d expected 7", cnt_z);
        end
        n_cmp++;
        if (rd_a_n !== 32'hFFFFFFFF || cnt_n !== 4'd8) begin
            n_err++;
            $display("FAIL plain_entry0: got %h cnt %0d expected ffffffff cnt 8", rd_a_n, cnt_n);
        end
        // A dropped zero-register write must not bypass either.
        drive(1'b1, 3'd0, 32'h00000123);
        #1;
        n_cmp++;
        if (rd_a_z !== '0 || rd_b_z !== '0) begin
            n_err++;
            $display("FAIL zero_reg_no_bypass: got %h/%h expected 0", rd_a_z, rd_b_z);
        end
        tick();
        we = 1'b0;
    endtask

    task automatic test_bypass();
        write_reg(3'd3, 32'hAAAA0000);
        drive(1'b1, 3'd3, 32'h0000BBBB);
        raddr_a = 3'd3;
        raddr_b = 3'd3;
        #1;
        n_cmp++;
        if (rd_a_z !== 32'h0000BBBB || rd_b_z !== 32'h0000BBBB) begin
            n_err++;
            $display("FAIL bypass_write_first: got %h/%h expected 0000bbbb", rd_a_z, rd_b_z);
        end
        n_cmp++;
        if (rd_a_n !== 32'hAAAA0000 || rd_b_n !== 32'hAAAA0000) begin
            n_err++;
            $display("FAIL bypass_read_old: got %h/%h expected aaaa0000", rd_a_n, rd_b_n);
        end
        tick();
        we = 1'b0;
        #1;
        n_cmp++;
        if (rd_a_n !== 32'h0000BBBB || rd_b_n !== 32'h0000BBBB || rd_a_z !== 32'h0000BBBB) begin
            n_err++;
            $display("FAIL bypass_after_edge: got %h/%h/%h expected 0000bbbb", rd_a_n, rd_b_n, rd_a_z);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
            raddr_a = 3'($urandom_range(0, 7));
            raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            #1;
            exp_q.push_back(exp_z(raddr_a));
            exp_q.push_back(exp_z(raddr_b));
            exp_q.push_back(exp_n(raddr_a));
            exp_q.push_back(exp_n(raddr_b));
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_a_z !== e) begin
                n_err++;
                $display("FAIL rand_z_a[%0d]: got %h expected %h", n, rd_a_z, e);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_b_z !== e) begin
                n_err++;
                $display("FAIL rand_z_b[%0d]: got %h expected %h", n, rd_b_z, e);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_a_n !== e) begin
                n_err++;
                $display("FAIL rand_n_a[%0d]: got %h expected %h", n, rd_a_n, e);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_b_n !== e) begin
                n_err++;
                $display("FAIL rand_n_b[%0d]: got %h expected %h", n, rd_b_n, e);
            end
            tick();
            n_cmp++;
            if (cnt_z !== 4'(wc_z) || cnt_n !== 4'(wc_n)) begin
                n_err++;
                $display("FAIL rand_count[%0d]: got %0d/%0d expected %0d/%0d", n, cnt_z, cnt_n, wc_z, wc_n);
            end
        end
        we = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int n = 1; n <= 20; n++) begin
            write_reg(3'd2, $urandom);
            n_cmp++;
            if (cnt_z !== 4'(wc_z) || cnt_z !== 4'((n < 15) ? n : 15)) begin
                n_err++;
                $display("FAIL sat_count[%0d]: got %0d expected %0d", n, cnt_z, (n < 15) ? n : 15);
            end
        end
        n_cmp++;
        if (cnt_z !== 4'd15 || cnt_n !== 4'd15) begin
            n_err++;
            $display("FAIL sat_final: got %0d/%0d expected 15", cnt_z, cnt_n);
        end
    endtask

    task automatic test_mid_write_reset();
        @(negedge clk);
        we    = 1'b1;
        waddr = 3'd6;
        wdata = 32'h12345678;
        rst_n = 1'b0;
        model_clear();
        tick();
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        raddr_a = 3'd6;
        raddr_b = 3'd6;
        tick();
        n_cmp++;
        if (rd_a_z !== mem_z[6] || rd_a_z !== '0 || rd_b_n !== '0) begin
            n_err++;
            $display("FAIL mid_write_reset: got %h/%h expected 0", rd_a_z, rd_b_n);
        end
        n_cmp++;
        if (cnt_z !== 4'd0 || cnt_n !== 4'd0) begin
            n_err++;
            $display("FAIL mid_write_reset_count: got %0d/%0d expected 0", cnt_z, cnt_n);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = 3'd0;
        wdata   = '0;
        raddr_a = 3'd0;
        raddr_b = 3'd0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (rd_a_z !== '0 || cnt_z !== 4'd0 || cnt_n !== 4'd0) begin
            n_err++;
            $display("FAIL initial_reset: got %h cnt %0d expected 0", rd_a_z, cnt_z);
        end
        test_reset();
        test_sweep();
        test_zero_reg();
        test_bypass();
        test_random();
        test_saturation();
        test_mid_write_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
